// File: rtl/bitorder.sv
// Dibit re-orderer for the RMII receive path: collects LSB-first dibits into bytes and
// re-emits each byte MSB-dibit first. Define BITORDER_BYTECOUNT_EN to add the byte_count output.
module bitorder (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [1:0] axiod
`ifdef BITORDER_BYTECOUNT_EN
    ,
    output logic [15:0] byte_count
`endif
);

    logic [1:0] in_cnt;
    logic [7:0] collect;
    logic [7:0] buffer;
    logic [1:0] out_cnt;
    logic       out_active;
    logic       byte_done;

    // The 4th valid dibit completes the byte on the same edge it is accepted.
    assign byte_done = axiiv && (in_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt     <= 2'd0;
            collect    <= 8'd0;
            buffer     <= 8'd0;
            out_cnt    <= 2'd0;
            out_active <= 1'b0;
            axiov      <= 1'b0;
            axiod      <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments let every branch below see the pre-edge values,
            // so the output stage reads the old buffer while a new byte is being loaded into it.
            if (axiiv) begin
                collect[{in_cnt, 1'b0} +: 2] <= axiid;
                in_cnt                       <= in_cnt + 2'd1;
            end

            if (byte_done) begin
                buffer <= {axiid, collect[5:0]};
            end

            if (out_active) begin
                axiov   <= 1'b1;
                axiod   <= buffer[{~out_cnt, 1'b0} +: 2];
                out_cnt <= out_cnt + 2'd1;
                if (out_cnt == 2'd3) begin
                    out_active <= 1'b0;
                end
            end else begin
                axiov <= 1'b0;
                axiod <= 2'b00;
            end

            // A byte completing on the last output edge restarts emission with no gap.
            if (byte_done) begin
                out_cnt    <= 2'd0;
                out_active <= 1'b1;
            end
        end
    end

`ifdef BITORDER_BYTECOUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_count <= 16'd0;
        end else if (byte_done) begin
            byte_count <= byte_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bitorder.sv
// Directed self-checking bench for bitorder; expected dibits are hand-computed from the
// LSB-first input / MSB-first output ordering. Honours BITORDER_BYTECOUNT_EN when defined.
module tb_bitorder;

    logic       clk;
    logic       rst;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiov;
    logic [1:0] axiod;
`ifdef BITORDER_BYTECOUNT_EN
    logic [15:0] byte_count;
`endif

    int checks = 0;
    int errors = 0;

    bitorder dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiov (axiov),
        .axiod (axiod)
`ifdef BITORDER_BYTECOUNT_EN
        ,
        .byte_count (byte_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it; outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] d);
        axiiv = 1'b1;
        axiid = d;
        tick();
    endtask

    task automatic idle(input logic [1:0] junk);
        axiiv = 1'b0;
        axiid = junk;
        tick();
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [1:0] d);
        check({tag, "_v"}, {15'd0, axiov}, {15'd0, v});
        check({tag, "_d"}, {14'd0, axiod}, {14'd0, d});
    endtask

    initial begin
        rst   = 1'b1;
        axiiv = 1'b0;
        axiid = 2'b00;
        tick();
        rst = 1'b0;
        expect_out("reset", 1'b0, 2'b00);
`ifdef BITORDER_BYTECOUNT_EN
        check("reset_count", byte_count, 16'd0);
`endif

        // Partial byte then reset: it must be discarded.
        send(2'b01);
        send(2'b10);
        axiiv = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("partial_rst", 1'b0, 2'b00);

        // Byte 1 (01,01,01,11): nothing visible while it is collected.
        send(2'b01); expect_out("b1_in0", 1'b0, 2'b00);
        send(2'b01); expect_out("b1_in1", 1'b0, 2'b00);
        send(2'b01); expect_out("b1_in2", 1'b0, 2'b00);
        send(2'b11); expect_out("b1_in3", 1'b0, 2'b00);

        // Byte 2 (00,11,01,10) back-to-back while byte 1 is emitted.
        send(2'b00); expect_out("b1_out0", 1'b1, 2'b11);
        send(2'b11); expect_out("b1_out1", 1'b1, 2'b01);
        send(2'b01); expect_out("b1_out2", 1'b1, 2'b01);
        send(2'b10); expect_out("b1_out3", 1'b1, 2'b01);
        idle(2'b00); expect_out("b2_out0", 1'b1, 2'b10);
        idle(2'b00); expect_out("b2_out1", 1'b1, 2'b01);
        idle(2'b00); expect_out("b2_out2", 1'b1, 2'b11);
        idle(2'b00); expect_out("b2_out3", 1'b1, 2'b00);
        idle(2'b00); expect_out("b2_done", 1'b0, 2'b00);

        // Byte 3 with a stall carrying a junk dibit.
        send(2'b00); expect_out("b3_in0", 1'b0, 2'b00);
        send(2'b00); expect_out("b3_in1", 1'b0, 2'b00);
        idle(2'b11); expect_out("b3_stall", 1'b0, 2'b00);
        send(2'b00); expect_out("b3_in2", 1'b0, 2'b00);
        send(2'b00); expect_out("b3_in3", 1'b0, 2'b00);

        // Byte 4 (01,01,01,11) back-to-back after the stalled byte.
        send(2'b01); expect_out("b3_out0", 1'b1, 2'b00);
        send(2'b01); expect_out("b3_out1", 1'b1, 2'b00);
        send(2'b01); expect_out("b3_out2", 1'b1, 2'b00);
        send(2'b11); expect_out("b3_out3", 1'b1, 2'b00);
`ifdef BITORDER_BYTECOUNT_EN
        check("count_after_b4", byte_count, 16'd4);
`endif
        idle(2'b00); expect_out("b4_out0", 1'b1, 2'b11);
        idle(2'b00); expect_out("b4_out1", 1'b1, 2'b01);
        idle(2'b00); expect_out("b4_out2", 1'b1, 2'b01);
        idle(2'b00); expect_out("b4_out3", 1'b1, 2'b01);
        idle(2'b00); expect_out("b4_done", 1'b0, 2'b00);

        // Byte 5 (10,00,11,01 -> 01,11,00,10) aborted by reset during its 2nd output dibit.
        send(2'b10);
        send(2'b00);
        send(2'b11);
        send(2'b01); expect_out("b5_in3", 1'b0, 2'b00);
        idle(2'b00); expect_out("b5_out0", 1'b1, 2'b01);
        idle(2'b00); expect_out("b5_out1", 1'b1, 2'b11);
        // Reset wins over a simultaneous valid dibit.
        rst   = 1'b1;
        axiiv = 1'b1;
        axiid = 2'b11;
        tick();
        rst = 1'b0;
        expect_out("b5_abort", 1'b0, 2'b00);
`ifdef BITORDER_BYTECOUNT_EN
        check("count_after_rst", byte_count, 16'd0);
`endif
        idle(2'b00); expect_out("b5_gone0", 1'b0, 2'b00);
        idle(2'b00); expect_out("b5_gone1", 1'b0, 2'b00);

        // Byte 6 (11,10,01,00 -> 00,01,10,11) after the aborted output.
        send(2'b11); expect_out("b6_in0", 1'b0, 2'b00);
        send(2'b10); expect_out("b6_in1", 1'b0, 2'b00);
        send(2'b01); expect_out("b6_in2", 1'b0, 2'b00);
        send(2'b00); expect_out("b6_in3", 1'b0, 2'b00);
`ifdef BITORDER_BYTECOUNT_EN
        check("count_after_b6", byte_count, 16'd1);
`endif
        idle(2'b00); expect_out("b6_out0", 1'b1, 2'b00);
        idle(2'b00); expect_out("b6_out1", 1'b1, 2'b01);
        idle(2'b00); expect_out("b6_out2", 1'b1, 2'b10);
        idle(2'b00); expect_out("b6_out3", 1'b1, 2'b11);
        idle(2'b00); expect_out("b6_done", 1'b0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
